serial_adder_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 38 +++
 rtl/full_adder_bit.sv | 17 +
 rtl/half_adder.sv | 10 +
 rtl/serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default width
// and the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // A one-bit counter still needs a bit, so clamp the lower end to 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl. The overflow signal
// exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             overflow;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry_out, busy, overflow
  );
  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry_out, busy, overflow
  );
`else
  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry_out, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry_out, busy
  );
`endif
endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder slice built from two half adders and an OR for the carry.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;
  logic g0;
  logic g1;

  half_adder u_ha0 (.a(a),   .b(b),   .sum(p),   .carry(g0));
  half_adder u_ha1 (.a(p),   .b(cin), .sum(sum), .carry(g1));

  assign cout = g0 | g1;
endmodule

// File: rtl/half_adder.sv
// One-bit half adder datapath cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice stepped LSB first over WIDTH
// cycles. Define SERIAL_ADD_OVF_EN to add the signed-overflow flag.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c_next;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  full_adder_bit u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (s),
    .cout(c_next)
  );

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what lets the slice read carry and the LSBs while they shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.op_a;
            b_sr  <= bus.op_b;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {s, res_sr[WIDTH-1:1]};
          carry  <= c_next;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge.
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ c_next;
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = res_sr;
  assign bus.carry_out = carry;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.overflow  = ovf;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8; overflow
// checks are compiled in when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation from IDLE and wait (bounded) for out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    int n;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    check({tag, " in_ready_low"}, 32'(bus.in_ready), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf_cleared"}, 32'(bus.overflow), 32'd0);
`endif
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd8);
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] r1;
    logic       c1;
    logic       got;
    int         gap;
    int         n;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;

    // Reset values
    #2;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst result", 32'(bus.result), 32'h00);
    check("rst carry", 32'(bus.carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst overflow", 32'(bus.overflow), 32'd0);
`endif
    #10 rst_n = 1'b1;
    tick();

    // Basic add 0x03 + 0x05
    run_op(8'h03, 8'h05, "basic");
    check("basic result", 32'(bus.result), 32'h08);
    check("basic carry", 32'(bus.carry_out), 32'd0);
    finish_op("basic");

    // Unsigned wrap 0xFF + 0x01
    run_op(8'hFF, 8'h01, "wrap");
    check("wrap result", 32'(bus.result), 32'h00);
    check("wrap carry", 32'(bus.carry_out), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    check("wrap overflow", 32'(bus.overflow), 32'd0);
`endif
    finish_op("wrap");

    // Signed overflow 0x7F + 0x01
    run_op(8'h7F, 8'h01, "sovf");
    check("sovf result", 32'(bus.result), 32'h80);
    check("sovf carry", 32'(bus.carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("sovf overflow", 32'(bus.overflow), 32'd1);
`endif
    finish_op("sovf");

    // Backpressure: 0x12 + 0x34 held in DONE while in_valid/operands toggle
    run_op(8'h12, 8'h34, "bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~i[0];
      bus.op_a     = 8'(8'h11 * (i + 1));
      bus.op_b     = 8'(8'h22 * (i + 1));
      tick();
      check("bp result_stable", 32'(bus.result), 32'h46);
      check("bp in_ready_low", 32'(bus.in_ready), 32'd0);
      check("bp out_valid_held", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    check("bp carry", 32'(bus.carry_out), 32'd0);
    finish_op("bp");

    // Reset at cnt=3 of 0xAA + 0x55
    bus.op_a     = 8'hAA;
    bus.op_b     = 8'h55;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst result", 32'(bus.result), 32'h00);
    check("midrst carry", 32'(bus.carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("midrst overflow", 32'(bus.overflow), 32'd0);
`endif
    #2 rst_n = 1'b1;
    tick();
    run_op(8'h10, 8'h20, "postrst");
    check("postrst result", 32'(bus.result), 32'h30);
    check("postrst carry", 32'(bus.carry_out), 32'd0);
    finish_op("postrst");

    // Back-to-back: 0x01+0x01 then 0x80+0x80 with in_valid and out_ready held
    r1  = '0;
    c1  = 1'b1;
    got = 1'b0;
    gap = 0;
    bus.op_a      = 8'h01;
    bus.op_b      = 8'h01;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.out_valid && !got) begin
        r1  = bus.result;
        c1  = bus.carry_out;
        got = 1'b1;
      end
      if (bus.in_ready) begin
        gap      = k + 1;
        bus.op_a = 8'h80;
        bus.op_b = 8'h80;
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
    check("b2b accept_gap", 32'(gap), 32'd10);
    check("b2b first_result", 32'(r1), 32'h02);
    check("b2b first_carry", 32'(c1), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("b2b second_latency", 32'(n), 32'd8);
    check("b2b second_result", 32'(bus.result), 32'h00);
    check("b2b second_carry", 32'(bus.carry_out), 32'd1);
    tick();
    bus.out_ready = 1'b0;
    check("b2b idle_after", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
